// File: rtl/uart_pkg.sv
// uart_pkg: types and line constants shared by the UART transmit (and receive) blocks.
//   tx_state_t  : transmitter FSM state encoding
//   LINE_IDLE   : level of an idle serial line (also the stop-bit level)
//   START_LEVEL : level of the start bit
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_baud_timer.sv
// uart_tx_baud_timer: bit-period timer for the UART transmitter.
// Counts 0 .. CLKS_PER_BIT-1 while enabled and wraps; bit_tick marks the last cycle of a bit.
// Ports:
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   clear    : forces the count back to 0 on the next edge (pulsed on every state change)
//   enable   : count only while a frame is in progress
//   bit_tick : high while the count equals CLKS_PER_BIT-1
module uart_tx_baud_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            if (bit_tick) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CntOne;
            end
        end
    end

    assign bit_tick = (cnt_q == CntMax);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter.
// Accepts a word over a ready/valid handshake and sends start bit, DATA_BITS data bits LSB
// first, optional even-parity bit and one stop bit, each CLKS_PER_BIT clocks long.
// Build option: define UART_TX_PARITY_EN to add the even-parity bit (PARITY state).
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset, aborts any frame in progress
//   tx_data    : word to send, sampled only on the handshake edge
//   tx_valid   : source has a word to send
//   tx_ready   : block can accept a word (IDLE only)
//   serial_out : registered serial line, idles high
//   tx_busy    : frame in progress (any state but IDLE)
//   tx_done    : one-cycle pulse on the final cycle of the stop bit
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 serial_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned BitCntW = $clog2(DATA_BITS);
    localparam logic [BitCntW-1:0] BitLast = BitCntW'(DATA_BITS - 1);
    localparam logic [BitCntW-1:0] BitOne  = BitCntW'(1);

    tx_state_t              state_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [BitCntW-1:0]     bit_cnt_q;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q;
`endif

    logic bit_tick;
    logic last_bit;
    logic state_change;

    assign last_bit = (bit_cnt_q == BitLast);

    // Mirrors the transition conditions of the FSM below so the baud timer restarts its
    // count on exactly the edge where the state register moves.
    always_comb begin
        state_change = 1'b0;
        case (state_q)
            IDLE:        state_change = tx_valid;
            START:       state_change = bit_tick;
            DATA:        state_change = bit_tick && last_bit;
`ifdef UART_TX_PARITY_EN
            PARITY:      state_change = bit_tick;
`endif
            STOP:        state_change = bit_tick;
            default:     state_change = 1'b1;
        endcase
    end

    uart_tx_baud_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_change),
        .enable   (tx_busy),
        .bit_tick (bit_tick)
    );

    // serial_out is assigned alongside each state move so the line level always matches the
    // state it is entering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            serial_out <= LINE_IDLE;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        state_q    <= START;
                        shift_q    <= tx_data;
                        bit_cnt_q  <= '0;
                        serial_out <= START_LEVEL;
`ifdef UART_TX_PARITY_EN
                        parity_q   <= ^tx_data;
`endif
                    end
                end
                START: begin
                    if (bit_tick) begin
                        state_q    <= DATA;
                        serial_out <= shift_q[0];
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
                        if (last_bit) begin
                            bit_cnt_q  <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q    <= PARITY;
                            serial_out <= parity_q;
`else
                            state_q    <= STOP;
                            serial_out <= LINE_IDLE;
`endif
                        end else begin
                            bit_cnt_q  <= bit_cnt_q + BitOne;
                            // Next data bit is the one about to land in bit 0.
                            serial_out <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        state_q    <= STOP;
                        serial_out <= LINE_IDLE;
                    end
                end
`endif
                STOP: begin
                    if (bit_tick) begin
                        state_q    <= IDLE;
                        serial_out <= LINE_IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    bit_cnt_q  <= '0;
                    serial_out <= LINE_IDLE;
                end
            endcase
        end
    end

    assign tx_ready = (state_q == IDLE);
    assign tx_busy  = (state_q != IDLE);
    assign tx_done  = (state_q == STOP) && bit_tick;

endmodule
